// File: rtl/run_monitor.sv
// run_monitor: run-control and halt/watchdog monitor for the 8-bit machine.
// Gates the CPU clock enable, counts run cycles, and detects a CPU halt or a
// watchdog expiry. At the terminating cycle it snapshots the register file,
// which can then be read back one register at a time through snap_sel/snap_data.
module run_monitor #(
  parameter  int DATA_W         = 8,
  parameter  int NUM_REGS       = 8,
  parameter  int TIMEOUT_CYCLES = 10000,
  localparam int SEL_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       halted,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [SEL_W-1:0]           snap_sel,
  output logic [DATA_W-1:0]          snap_data,
  output logic                       cpu_run,
  output logic                       done,
  output logic                       timed_out,
  output logic [CNT_W-1:0]           cycle_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t              state;
  logic [DATA_W-1:0]   snapshot [NUM_REGS];
  logic                capture;

  // A run ends on the edge where the CPU reports halt or the count reaches its last value
  assign capture = (state == RUN) && (halted || (cycle_count == LAST_COUNT));

  // Status outputs come straight from the registered state, so reset clears them at once
  assign cpu_run   = (state == RUN);
  assign done      = (state == HALTED) || (state == TIMEOUT);
  assign timed_out = (state == TIMEOUT);

  // Run-control FSM and cycle counter; halt takes priority over the watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            cycle_count <= '0;
          end
        end
        RUN: begin
          if (halted) begin
            state <= HALTED;
          end else if (cycle_count == LAST_COUNT) begin
            state       <= TIMEOUT;
            cycle_count <= MAX_COUNT;
          end else begin
            cycle_count <= cycle_count + ONE;
          end
        end
        HALTED, TIMEOUT: begin
          if (clear) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register-file snapshot taken only on the terminating edge, held until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snapshot[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snapshot[i] <= regs_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // Readback port with one cycle of latency; out-of-range selects read as zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_data <= '0;
    end else if (int'(snap_sel) < NUM_REGS) begin
      snap_data <= snapshot[snap_sel];
    end else begin
      snap_data <= '0;
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed plus randomized bench for run_monitor.
// Expected results come from the run length rule: a run that sees halt at
// edge k ends HALTED with count k when k < TIMEOUT_CYCLES, otherwise it ends
// TIMEOUT with count TIMEOUT_CYCLES; the snapshot is the register value
// presented on the terminating edge.
module tb_run_monitor;

  localparam int DATA_W         = 8;
  localparam int NUM_REGS       = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int SEL_W          = 3;
  localparam int CNT_W          = 5;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       start = 1'b0;
  logic                       clear = 1'b0;
  logic                       halted = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] regs_flat = '0;
  logic [SEL_W-1:0]           snap_sel = '0;
  logic [DATA_W-1:0]          snap_data;
  logic                       cpu_run;
  logic                       done;
  logic                       timed_out;
  logic [CNT_W-1:0]           cycle_count;

  int                total = 0;
  int                bad = 0;
  logic              hold_regs = 1'b0;
  logic [DATA_W-1:0] exp_snap [NUM_REGS];
  int                exp_count = 0;

  run_monitor #(
    .DATA_W(DATA_W),
    .NUM_REGS(NUM_REGS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .clear(clear),
    .halted(halted),
    .regs_flat(regs_flat),
    .snap_sel(snap_sel),
    .snap_data(snap_data),
    .cpu_run(cpu_run),
    .done(done),
    .timed_out(timed_out),
    .cycle_count(cycle_count)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_regs();
    regs_flat = {$urandom, $urandom};
  endtask

  // One complete run where halted rises on RUN edge halt_at (>15 means never in time)
  task automatic apply_stimulus(input int halt_at);
    int last;
    bit to;
    to        = (halt_at >= TIMEOUT_CYCLES);
    last      = to ? (TIMEOUT_CYCLES - 1) : halt_at;
    exp_count = to ? TIMEOUT_CYCLES : halt_at;
    halted = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check_output("run_entry_cpu_run", 32'(cpu_run), 32'd1);
    check_output("run_entry_count", 32'(cycle_count), 32'd0);
    for (int n = 0; n <= last; n++) begin
      if (!hold_regs) randomize_regs();
      halted = (n >= halt_at);
      start  = 1'($urandom_range(0, 1));
      clear  = 1'($urandom_range(0, 1));
      if (n == last) begin
        for (int i = 0; i < NUM_REGS; i++) exp_snap[i] = regs_flat[i*DATA_W +: DATA_W];
      end
      tick();
      if (n < last) begin
        check_output("running_cpu_run", 32'(cpu_run), 32'd1);
        check_output("running_count", 32'(cycle_count), 32'(n + 1));
      end
    end
    start = 1'b0;
    clear = 1'b0;
    check_output("end_done", 32'(done), 32'd1);
    check_output("end_timed_out", 32'(timed_out), 32'(to));
    check_output("end_count", 32'(cycle_count), 32'(exp_count));
    check_output("end_cpu_run", 32'(cpu_run), 32'd0);
  endtask

  // Read every snapshot register while the live bus keeps changing
  task automatic read_snapshot();
    for (int i = 0; i < NUM_REGS; i++) begin
      snap_sel = SEL_W'(i);
      if (!hold_regs) randomize_regs();
      tick();
      check_output("snap_read", 32'(snap_data), 32'(exp_snap[i]));
    end
  endtask

  task automatic clear_run();
    halted = 1'b0;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    check_output("clear_done", 32'(done), 32'd0);
    check_output("clear_cpu_run", 32'(cpu_run), 32'd0);
    check_output("clear_count_kept", 32'(cycle_count), 32'(exp_count));
  endtask

  initial begin
    // Reset held low while inputs toggle randomly
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start    = 1'($urandom_range(0, 1));
      clear    = 1'($urandom_range(0, 1));
      halted   = 1'($urandom_range(0, 1));
      snap_sel = SEL_W'($urandom_range(0, NUM_REGS - 1));
      randomize_regs();
      tick();
      check_output("rst_cpu_run", 32'(cpu_run), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_timed_out", 32'(timed_out), 32'd0);
      check_output("rst_count", 32'(cycle_count), 32'd0);
      check_output("rst_snap_data", 32'(snap_data), 32'd0);
    end
    start  = 1'b0;
    clear  = 1'b0;
    halted = 1'b0;
    reset  = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check_output("idle_cpu_run", 32'(cpu_run), 32'd0);
    check_output("idle_done", 32'(done), 32'd0);

    // Halt after five RUN cycles with known A and G values
    randomize_regs();
    regs_flat[0*DATA_W +: DATA_W] = 8'h2A;
    regs_flat[6*DATA_W +: DATA_W] = 8'h7F;
    hold_regs = 1'b1;
    apply_stimulus(5);
    snap_sel = 3'd0;
    tick();
    check_output("snap_A", 32'(snap_data), 32'h2A);
    snap_sel = 3'd6;
    tick();
    check_output("snap_G", 32'(snap_data), 32'h7F);
    hold_regs = 1'b0;
    read_snapshot();
    clear_run();

    // Watchdog expiry with halted held low
    apply_stimulus(1000);
    read_snapshot();
    clear_run();

    // Halt on the terminal-count edge: halt wins
    apply_stimulus(TIMEOUT_CYCLES - 1);
    read_snapshot();
    clear_run();

    // Halt already asserted on the first RUN edge
    apply_stimulus(0);
    read_snapshot();
    clear_run();

    // Reset in the middle of a run aborts at once
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      randomize_regs();
      tick();
    end
    check_output("pre_abort_count", 32'(cycle_count), 32'd3);
    reset = 1'b0;
    #1;
    check_output("abort_cpu_run", 32'(cpu_run), 32'd0);
    check_output("abort_count", 32'(cycle_count), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_snap[i] = '0;
    read_snapshot();
    apply_stimulus(int'($urandom_range(1, 12)));
    read_snapshot();
    clear_run();

    // Start ignored while done; clear+start returns to IDLE only
    apply_stimulus(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("done_start_ignored", 32'(done), 32'd1);
    check_output("done_count_held", 32'(cycle_count), 32'd2);
    check_output("done_no_run", 32'(cpu_run), 32'd0);
    halted = 1'b0;
    clear  = 1'b1;
    start  = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check_output("clr_start_done", 32'(done), 32'd0);
    check_output("clr_start_no_run", 32'(cpu_run), 32'd0);
    tick();
    tick();
    check_output("clr_start_still_idle", 32'(cpu_run), 32'd0);
    apply_stimulus(3);
    clear_run();

    // Randomized runs of varying length
    for (int r = 0; r < 12; r++) begin
      apply_stimulus(int'($urandom_range(0, 20)));
      read_snapshot();
      clear_run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
